// File: rtl/reg_mem_access_arbiter_if.sv
// Bundle of requester handshakes and SRAM macro signals around the snapshot memory arbiter.
// The arbiter takes the slave view; a requester/memory environment takes the master view.
interface reg_mem_access_arbiter_if #(
    parameter int REQ_CNT     = 4,
    parameter int ENTRY_WIDTH = 7,
    parameter int MEM_WIDTH   = 36
);
    logic [REQ_CNT-1:0]             req_vld;
    logic [REQ_CNT-1:0]             req_rd_en;
    logic [REQ_CNT-1:0]             req_wr_en;
    logic [REQ_CNT*ENTRY_WIDTH-1:0] req_addr;
    logic [REQ_CNT*MEM_WIDTH-1:0]   req_wr_data;
    logic [REQ_CNT-1:0]             ack_vld;
    logic [MEM_WIDTH-1:0]           rd_data;
    logic                           mem_ce;
    logic                           mem_we;
    logic [ENTRY_WIDTH-1:0]         mem_addr;
    logic [MEM_WIDTH-1:0]           mem_wdata;
    logic [MEM_WIDTH-1:0]           mem_rdata;
    logic                           busy;
    logic                           err_rw;

    modport slave (
        input  req_vld, req_rd_en, req_wr_en, req_addr, req_wr_data, mem_rdata,
        output ack_vld, rd_data, mem_ce, mem_we, mem_addr, mem_wdata, busy, err_rw
    );

    modport master (
        output req_vld, req_rd_en, req_wr_en, req_addr, req_wr_data, mem_rdata,
        input  ack_vld, rd_data, mem_ce, mem_we, mem_addr, mem_wdata, busy, err_rw
    );
endinterface

// File: rtl/reg_mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port entry SRAM among REQ_CNT snapshot front ends.
// One transaction at a time: IDLE -> ACCESS -> (WAIT x RD_LATENCY) -> ACK, all outputs registered.
module reg_mem_access_arbiter #(
    parameter int REQ_CNT     = 4,
    parameter int ENTRY_WIDTH = 7,
    parameter int MEM_WIDTH   = 36,
    parameter int RD_LATENCY  = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    reg_mem_access_arbiter_if.slave bus
);
    localparam int IDX_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_ACCESS = 4'b0010,
        ST_WAIT   = 4'b0100,
        ST_ACK    = 4'b1000
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d, grant_q, grant_d;
    logic [ENTRY_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [MEM_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                   err_q, err_d;
    logic [REQ_CNT-1:0]     ack_q, ack_d;
    logic                   ce_q, ce_d, we_q, we_d, busy_q, busy_d;
    logic [ENTRY_WIDTH-1:0] maddr_q, maddr_d;
    logic [MEM_WIDTH-1:0]   mwdata_q, mwdata_d;

    logic                   pick_vld_s;
    logic [IDX_W-1:0]       pick_idx_s, cand_s;

    // Round-robin pick: scan backwards so the candidate closest to the pointer wins last.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = '0;
        cand_s     = '0;
        for (int i = REQ_CNT - 1; i >= 0; i--) begin
            cand_s = IDX_W'((int'(ptr_q) + i) % REQ_CNT);
            if (bus.req_vld[cand_s]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = cand_s;
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
    end

    // Next-state, transaction capture and registered-output decode.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    grant_d = pick_idx_s;
                    addr_d  = bus.req_addr[int'(pick_idx_s)*ENTRY_WIDTH +: ENTRY_WIDTH];
                    wdata_d = bus.req_wr_data[int'(pick_idx_s)*MEM_WIDTH +: MEM_WIDTH];
                    wr_d    = bus.req_wr_en[pick_idx_s];
                    err_d   = err_q | (bus.req_wr_en[pick_idx_s] & bus.req_rd_en[pick_idx_s]);
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (wr_q) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d   = 3'(RD_LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rd_data_d = bus.mem_rdata;
                    state_d   = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK: begin
                // Just-served requester drops to lowest priority.
                ptr_d   = (grant_q == IDX_W'(REQ_CNT - 1)) ? '0 : grant_q + IDX_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ce_d     = (state_d == ST_ACCESS);
        we_d     = ce_d & wr_d;
        maddr_d  = ce_d ? addr_d : '0;
        mwdata_d = ce_d ? wdata_d : '0;
        ack_d    = (state_d == ST_ACK) ? ({{(REQ_CNT-1){1'b0}}, 1'b1} << grant_d) : '0;
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any transaction without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            cnt_q     <= 3'd0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            ack_q     <= '0;
            ce_q      <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
            ack_q     <= ack_d;
            ce_q      <= ce_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
        end
    end

    assign bus.ack_vld   = ack_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.mem_ce    = ce_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = mwdata_q;
    assign bus.busy      = busy_q;
    assign bus.err_rw    = err_q;
endmodule

// File: tb/tb_reg_mem_access_arbiter.sv
// Self-checking bench: vector table plus hand sequences for arbitration order, read latency and reset abort.
// A small SRAM model backs the latency-1 instance; a cycle counter feeds the latency-3 instance.
module tb_reg_mem_access_arbiter;
    localparam int RC = 4;
    localparam int EW = 7;
    localparam int MW = 36;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_mem_access_arbiter_if #(.REQ_CNT(RC), .ENTRY_WIDTH(EW), .MEM_WIDTH(MW)) bus ();
    reg_mem_access_arbiter_if #(.REQ_CNT(RC), .ENTRY_WIDTH(EW), .MEM_WIDTH(MW)) bus3 ();

    reg_mem_access_arbiter #(.REQ_CNT(RC), .ENTRY_WIDTH(EW), .MEM_WIDTH(MW), .RD_LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    reg_mem_access_arbiter #(.REQ_CNT(RC), .ENTRY_WIDTH(EW), .MEM_WIDTH(MW), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    int n_cmp = 0;
    int n_err = 0;

    // Single-port SRAM model with one cycle read latency.
    logic [MW-1:0] mem [0:127];
    always @(posedge clk) begin
        if (bus.mem_ce && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_ce && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Read data for the latency-3 instance changes every cycle so the capture cycle is visible.
    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;
    assign bus3.mem_rdata = {4'hC, cyc};

    typedef struct {
        int          idx;
        logic [MW-1:0] rdata;
    } sb_t;
    sb_t sbq[$];
    sb_t sb_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every ack pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.ack_vld != 4'b0000) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_ack", 64'(bus.ack_vld), 64'd0);
            end else begin
                sb_e = sbq.pop_front();
                chk("sb_ack_vld", 64'(bus.ack_vld), 64'(4'b0001 << sb_e.idx));
                chk("sb_rd_data", 64'(bus.rd_data), 64'(sb_e.rdata));
            end
        end
    end

    task automatic set_req(input int i, input int op, input logic [EW-1:0] a, input logic [MW-1:0] d);
        bus.req_vld[i]             = 1'b1;
        bus.req_rd_en[i]           = (op == 0 || op == 3);
        bus.req_wr_en[i]           = (op == 1 || op == 3);
        bus.req_addr[i*EW +: EW]   = a;
        bus.req_wr_data[i*MW +: MW] = d;
    endtask

    task automatic clr_req(input int i);
        bus.req_vld[i]   = 1'b0;
        bus.req_rd_en[i] = 1'b0;
        bus.req_wr_en[i] = 1'b0;
    endtask

    // One request on an idle DUT; op 0=rd 1=wr 2=neither 3=both.
    task automatic run_txn(input int i, input int op, input logic [EW-1:0] a, input logic [MW-1:0] d,
                           input logic [MW-1:0] exp_rd, input string tag);
        bit is_wr;
        int lat;
        bit got;
        is_wr = (op == 1 || op == 3);
        sbq.push_back('{i, exp_rd});
        set_req(i, op, a, d);
        @(posedge clk); #1;
        chk({tag, "_mem_ce"}, 64'(bus.mem_ce), 64'd1);
        chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'(is_wr));
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(a));
        if (is_wr) chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(d));
        lat = 1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.ack_vld[i]) got = 1'b1;
        end
        chk({tag, "_ack_latency"}, 64'(got ? lat : -1), 64'(is_wr ? 2 : 3));
        clr_req(i);
        @(posedge clk); #1;
    endtask

    // Several requesters at once; each drops its request after its own ack. Reads hit 20+i holding i.
    task automatic multi(input logic [3:0] mask, input int op, input int e0, input int e1, input int e2,
                         input int e3, input logic [MW-1:0] hold, input string tag);
        int exp_o[4];
        int got_o[4];
        int n;
        int ne;
        exp_o = '{e0, e1, e2, e3};
        got_o = '{-1, -1, -1, -1};
        n = 0;
        ne = $countones(mask);
        for (int j = 0; j < ne; j++) sbq.push_back('{exp_o[j], (op == 1) ? hold : MW'(exp_o[j])});
        for (int i = 0; i < RC; i++) if (mask[i]) set_req(i, op, EW'(20 + i), MW'(i));
        for (int k = 0; k < 60 && n < ne; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < RC; i++) begin
                if (bus.ack_vld[i]) begin
                    if (n < 4) got_o[n] = i;
                    n++;
                    clr_req(i);
                end
            end
        end
        chk({tag, "_ack_count"}, 64'(n), 64'(ne));
        for (int j = 0; j < ne; j++) chk($sformatf("%s_order%0d", tag, j), 64'(got_o[j]), 64'(exp_o[j]));
        @(posedge clk); #1;
    endtask

    typedef struct {
        int            idx;
        int            op;
        logic [EW-1:0] addr;
        logic [MW-1:0] wd;
        logic [MW-1:0] exp_rd;
        logic          exp_err;
    } vec_t;
    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int lat3;
        int waitc;
        bit got3;

        vt[0] = '{0, 0, 7'h05, 36'h0,           36'h9_1234_5678, 1'b0};
        vt[1] = '{2, 1, 7'h7F, 36'hA_DEAD_BEEF, 36'h9_1234_5678, 1'b0};
        vt[2] = '{1, 0, 7'h7F, 36'h0,           36'hA_DEAD_BEEF, 1'b0};
        vt[3] = '{3, 1, 7'h00, 36'h0_0000_0001, 36'hA_DEAD_BEEF, 1'b0};
        vt[4] = '{0, 0, 7'h00, 36'h0,           36'h0_0000_0001, 1'b0};
        vt[5] = '{1, 2, 7'h05, 36'h0,           36'h9_1234_5678, 1'b0};
        vt[6] = '{2, 3, 7'h10, 36'h5_5555_AAAA, 36'h9_1234_5678, 1'b1};
        vt[7] = '{3, 0, 7'h10, 36'h0,           36'h5_5555_AAAA, 1'b1};

        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[5] = 36'h9_1234_5678;
        bus.req_vld = '0;  bus.req_rd_en = '0;  bus.req_wr_en = '0;
        bus.req_addr = '0; bus.req_wr_data = '0;
        bus3.req_vld = '0; bus3.req_rd_en = '0; bus3.req_wr_en = '0;
        bus3.req_addr = '0; bus3.req_wr_data = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_vld", 64'(bus.ack_vld), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_mem_ce", 64'(bus.mem_ce), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
        chk("rst_err_rw", 64'(bus.err_rw), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 64'(bus.busy), 64'd0);

        for (int v = 0; v < 8; v++) begin
            run_txn(vt[v].idx, vt[v].op, vt[v].addr, vt[v].wd, vt[v].exp_rd, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_err_rw", v), 64'(bus.err_rw), 64'(vt[v].exp_err));
            chk($sformatf("vec%0d_rd_data_hold", v), 64'(bus.rd_data), 64'(vt[v].exp_rd));
        end

        multi(4'b1111, 1, 0, 1, 2, 3, 36'h5_5555_AAAA, "all_four");
        run_txn(2, 0, 7'd22, 36'h0, 36'd2, "solo2");
        multi(4'b0101, 0, 0, 2, 0, 0, 36'h0, "pair02");
        run_txn(1, 0, 7'd21, 36'h0, 36'd1, "solo1");
        multi(4'b1011, 0, 3, 0, 1, 0, 36'h0, "rotate301");

        // Latency-3 read: three WAIT cycles, capture during cycle T+4, ack at T+5.
        c0 = int'(cyc);
        bus3.req_vld[1] = 1'b1;
        bus3.req_rd_en[1] = 1'b1;
        bus3.req_addr[1*EW +: EW] = 7'h03;
        @(posedge clk); #1;
        chk("lat3_mem_ce", 64'(bus3.mem_ce), 64'd1);
        chk("lat3_mem_we", 64'(bus3.mem_we), 64'd0);
        chk("lat3_mem_addr", 64'(bus3.mem_addr), 64'h03);
        lat3 = 1;
        waitc = 0;
        got3 = 1'b0;
        for (int k = 0; k < 12 && !got3; k++) begin
            @(posedge clk); #1;
            lat3++;
            if (bus3.ack_vld != 4'b0000) got3 = 1'b1;
            else if (bus3.busy && !bus3.mem_ce) waitc++;
        end
        chk("lat3_ack_latency", 64'(got3 ? lat3 : -1), 64'd5);
        chk("lat3_ack_vld", 64'(bus3.ack_vld), 64'(4'b0010));
        chk("lat3_wait_cycles", 64'(waitc), 64'd3);
        chk("lat3_rd_data", 64'(bus3.rd_data), 64'({4'hC, 32'(c0 + 4)}));
        bus3.req_vld[1] = 1'b0;
        bus3.req_rd_en[1] = 1'b0;
        @(posedge clk); #1;

        // Reset during WAIT: everything clears at once and no ack follows.
        set_req(3, 0, 7'h05, 36'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_wait_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_mem_ce", 64'(bus.mem_ce), 64'd0);
        chk("abort_ack_vld", 64'(bus.ack_vld), 64'd0);
        chk("abort_rd_data", 64'(bus.rd_data), 64'd0);
        chk("abort_err_rw", 64'(bus.err_rw), 64'd0);
        clr_req(3);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_abort_ack_vld", 64'(bus.ack_vld), 64'd0);
        run_txn(1, 1, 7'h09, 36'h1_2345_6789, 36'h0, "post_rst_wr");
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
